// File: rtl/adpcm5205_pkg.sv
// Shared constants for the MSM5205 ADPCM decoder clone:
// step table, index adjust table, divider ratios, sample width.
package adpcm5205_pkg;

  localparam int SAMPLE_W = 12;
  localparam int IDX_W    = 6;

  localparam logic [IDX_W-1:0] IDX_MAX = 6'd48;

  localparam logic [6:0] DIV_4K = 7'd96;
  localparam logic [6:0] DIV_6K = 7'd64;
  localparam logic [6:0] DIV_8K = 7'd48;

  localparam logic [1:0] SEL_HALT = 2'd3;

  localparam logic [10:0] STEP_TABLE [49] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,
    11'd25,   11'd28,   11'd31,   11'd34,   11'd37,
    11'd41,   11'd45,   11'd50,   11'd55,   11'd60,
    11'd66,   11'd73,   11'd80,   11'd88,   11'd97,
    11'd107,  11'd118,  11'd130,  11'd143,  11'd157,
    11'd173,  11'd190,  11'd209,  11'd230,  11'd253,
    11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
    11'd724,  11'd796,  11'd876,  11'd963,  11'd1060,
    11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  localparam logic signed [6:0] ADJ [8] = '{
    -7'sd1, -7'sd1, -7'sd1, -7'sd1,
    7'sd2,  7'sd4,  7'sd6,  7'sd8
  };

  function automatic logic [6:0] div_n(input logic [1:0] s);
    logic [6:0] n;
    unique case (s)
      2'd1:    n = DIV_6K;
      2'd2:    n = DIV_8K;
      default: n = DIV_4K;
    endcase
    return n;
  endfunction

  function automatic logic [10:0] step_of(input logic [IDX_W-1:0] i);
    if (i > IDX_MAX) return STEP_TABLE[IDX_MAX];
    return STEP_TABLE[i];
  endfunction

endpackage

// File: rtl/adpcm5205_dec.sv
// Combinational ADPCM step: (acc, idx, nibble) -> (acc_next, idx_next).
// Ports: acc/idx current state, nibble input; acc_next saturated, idx_next clamped.
module adpcm5205_dec
  import adpcm5205_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] acc,
  input  logic [IDX_W-1:0]           idx,
  input  logic [3:0]                 nibble,
  output logic signed [SAMPLE_W-1:0] acc_next,
  output logic [IDX_W-1:0]           idx_next
);

  logic [10:0]        step;
  logic [12:0]        diff;
  logic signed [13:0] delta;
  logic signed [13:0] sum;
  logic signed [6:0]  idx_sum;

  always_comb begin
    step = step_of(idx);
    // each term truncated on its own, as the original chip does
    diff = {2'b0, step >> 3}
         + {2'b0, nibble[0] ? (step >> 2) : 11'd0}
         + {2'b0, nibble[1] ? (step >> 1) : 11'd0}
         + {2'b0, nibble[2] ? step : 11'd0};
    delta = $signed({1'b0, diff});
    if (nibble[3]) delta = -delta;
    sum = $signed({{2{acc[SAMPLE_W-1]}}, acc}) + delta;

    if (sum > 14'sd2047)
      acc_next = 12'sd2047;
    else if (sum < -14'sd2048)
      acc_next = -12'sd2048;
    else
      acc_next = sum[SAMPLE_W-1:0];

    idx_sum = $signed({1'b0, idx}) + ADJ[nibble[2:0]];
    if (idx_sum < 7'sd0)
      idx_next = '0;
    else if (idx_sum > $signed({1'b0, IDX_MAX}))
      idx_next = IDX_MAX;
    else
      idx_next = idx_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/adpcm5205_decoder.sv
// MSM5205 clone top: rate divider, irq strobe, nibble decode state.
// Ports: clk, rst (sync, low), cen tick, din nibble, sel rate; sound, irq out.
module adpcm5205_decoder
  import adpcm5205_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cen,
  input  logic [3:0]                 din,
  input  logic [1:0]                 sel,
  output logic signed [SAMPLE_W-1:0] sound,
  output logic                       irq
);

  logic [6:0]  cnt;
  logic [6:0]  cnt_nxt;
  logic [6:0]  n_sel;
  logic [6:0]  n_eff;
  logic [6:0]  half;
  logic [1:0]  rate;
  logic        halt;
  logic        wrap;
  logic        dec_en;

  logic signed [SAMPLE_W-1:0] acc;
  logic signed [SAMPLE_W-1:0] acc_nxt;
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           idx_nxt;

  adpcm5205_dec u_dec (
    .acc      (acc),
    .idx      (idx),
    .nibble   (din),
    .acc_next (acc_nxt),
    .idx_next (idx_nxt)
  );

  // rate is latched at count 0, so a sel change waits for the wrap;
  // a count already past the new ratio forces an early wrap
  always_comb begin
    halt    = (sel == SEL_HALT);
    n_sel   = div_n(sel);
    n_eff   = (cnt == 7'd0) ? n_sel : div_n(rate);
    half    = n_eff >> 1;
    wrap    = (cnt >= n_eff - 7'd1) || (cnt >= n_sel);
    cnt_nxt = wrap ? 7'd0 : cnt + 7'd1;
    dec_en  = !halt && (cnt == half);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      rate <= '0;
      irq  <= 1'b0;
      acc  <= '0;
      idx  <= '0;
    end else if (cen) begin
      if (halt) begin
        cnt <= '0;
        irq <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        irq <= (cnt < half);
        if (cnt == 7'd0) rate <= sel;
      end
      if (dec_en) begin
        acc <= acc_nxt;
        idx <= idx_nxt;
      end
    end
  end

  assign sound = acc;

endmodule

// File: tb/tb_adpcm5205_decoder.sv
// Directed bench for adpcm5205_decoder: irq timing, decode values,
// saturation, rate sweep, halt, mid-period reset, frozen cen.
module tb_adpcm5205_decoder;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cen = 1'b0;
  logic [3:0]        din = 4'd0;
  logic [1:0]        sel = 2'd0;
  logic signed [11:0] sound;
  logic              irq;

  int   tests = 0;
  int   fails = 0;
  bit   cen_on = 1'b1;
  logic [1:0] cdiv = 2'd0;

  adpcm5205_decoder dut (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .din   (din),
    .sel   (sel),
    .sound (sound),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // one cen every 4th clk, driven away from the active edge
  always @(negedge clk) begin
    if (cen_on) begin
      cdiv = cdiv + 2'd1;
      cen  = (cdiv == 2'd0);
    end else begin
      cen = 1'b0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input logic lvl, output int n);
    n = 0;
    while (irq !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (irq !== lvl) chk("irq_timeout", 0, 1);
  endtask

  task automatic wait_dec();
    int n;
    wait_edge(1'b1, n);
    wait_edge(1'b0, n);
  endtask

  task automatic measure(output int hi, output int per);
    int n;
    int lo;
    wait_edge(1'b0, n);
    wait_edge(1'b1, n);
    wait_edge(1'b0, hi);
    wait_edge(1'b1, lo);
    per = hi + lo;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n, hi, per, cnt_hi;
    logic signed [11:0] held;
    logic held_irq;

    // reset state
    rst = 1'b0;
    sel = 2'd0;
    din = 4'd0;
    repeat (12) @(negedge clk);
    chk("rst_irq", int'(irq), 0);
    chk("rst_sound", int'(sound), 0);

    // release: first rise, 48-cen high, 96-cen period
    rst = 1'b1;
    wait_edge(1'b1, n);
    chk("first_rise_sound", int'(sound), 0);
    wait_edge(1'b0, hi);
    chk("irq_high_0", hi, 192);
    chk("dec_din0", int'(sound), 2);
    din = 4'd8;
    wait_edge(1'b1, n);
    chk("irq_period_0", hi + n, 384);
    wait_edge(1'b0, n);
    chk("dec_din8", int'(sound), 0);

    // din=7 twice from fresh start
    do_reset();
    din = 4'd7;
    wait_dec();
    chk("dec_7_a", int'(sound), 30);
    wait_dec();
    chk("dec_7_b", int'(sound), 93);

    // drive to positive saturation
    for (int i = 0; i < 18; i++) wait_dec();
    chk("sat_pos", int'(sound), 2047);
    wait_dec();
    chk("sat_pos_hold", int'(sound), 2047);

    // negative: idx pinned at 48, step 1552, diff 2910
    din = 4'hF;
    wait_dec();
    chk("neg_first", int'(sound), -863);
    wait_dec();
    chk("sat_neg", int'(sound), -2048);
    for (int i = 0; i < 4; i++) wait_dec();
    chk("sat_neg_hold", int'(sound), -2048);

    // rate sweep
    do_reset();
    din = 4'd0;
    measure(hi, per);
    chk("sweep_per_0", per, 384);
    sel = 2'd1;
    measure(hi, per);
    chk("sweep_per_1", per, 256);
    chk("sweep_hi_1", hi, 128);
    sel = 2'd2;
    measure(hi, per);
    chk("sweep_per_2", per, 192);
    chk("sweep_hi_2", hi, 96);

    // halt: irq stays low, sound held
    sel = 2'd3;
    repeat (8) @(negedge clk);
    held = sound;
    cnt_hi = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (irq) cnt_hi++;
    end
    chk("halt_irq", cnt_hi, 0);
    chk("halt_sound", int'(sound), int'(held));
    sel = 2'd0;
    measure(hi, per);
    chk("resume_per_0", per, 384);
    chk("resume_hi_0", hi, 192);

    // mid-period reset after a few decodes
    do_reset();
    din = 4'd7;
    wait_dec();
    wait_dec();
    wait_dec();
    chk("dec_7_c", int'(sound), 229);
    wait_edge(1'b1, n);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_sound", int'(sound), 0);
    chk("midrst_irq", int'(irq), 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    wait_dec();
    chk("after_rst_dec", int'(sound), 30);

    // no cen: everything frozen
    wait_edge(1'b1, n);
    @(negedge clk);
    cen_on = 1'b0;
    @(negedge clk);
    held = sound;
    held_irq = irq;
    din = 4'hF;
    repeat (500) @(negedge clk);
    chk("nocen_sound", int'(sound), int'(held));
    chk("nocen_irq", int'(irq), int'(held_irq));
    chk("nocen_irq_high", int'(irq), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adpcm5205_decoder.md
Name: adpcm5205_decoder

Overview:
- Cycle-level clone of the OKI MSM5205 4-bit ADPCM speech decoder.
- Runs from a system clock gated by a clock-enable `cen` at the nominal 384 kHz chip rate.
- Generates the sample-request strobe `irq` at a rate selected by `sel`, latches the 4-bit nibble on `din`, and outputs a signed 12-bit PCM sample.
- Sits between a ROM/CPU nibble feeder and the sound mixer.

Parameters:
- None. The sample rate is run-time selected through `sel`.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low (0 = reset)
- cen  in  1  clock enable; one pulse per 384 kHz chip tick
- din  in  4  ADPCM nibble: bit3 = sign, bits2:0 = magnitude
- sel  in  2  rate select: 0 = ÷96 (4 kHz), 1 = ÷64 (6 kHz), 2 = ÷48 (8 kHz), 3 = halt
- sound  out  12  signed PCM sample, two's complement
- irq  out  1  sample-request strobe (VCK equivalent)

Behaviour:
- All state advances only on clk edges where cen=1. The exception is reset, which acts on any clk edge with rst=0.
- Reset values:
  - sound = 0
  - irq = 0
  - step index = 0
  - accumulator = 0
  - divider counter = 0
- Reset asserted mid-sample aborts the period. The divider restarts at 0 after release.

Divider:
- N = 96/64/48 for sel = 0/1/2.
- The counter counts 0..N-1 on each cen and wraps to 0.
- irq = 1 while count < N/2, else 0. This gives a 50% duty strobe with its rising edge at count 0.
- irq is registered.

Sampling:
- din is latched on the cen where the counter reaches N/2 (irq falling).
- The feeder therefore has half a period after irq rises to present the nibble.

Decode, performed in that same cen cycle:
- `sound` and the step index update together.
- They are visible one clk after that cen.
- step = STEP_TABLE[idx].
- diff = (step>>3) + (b0 ? step>>2 : 0) + (b1 ? step>>1 : 0) + (b2 ? step : 0). Each term is truncated separately.
- If b3 = 1, diff is negated.
- acc_next = acc + diff, computed at 13+ bits, then saturated to [-2048, +2047].
- sound = acc_next.

Step index:
- idx += ADJ[din[2:0]], where ADJ = {-1,-1,-1,-1,+2,+4,+6,+8}.
- Result is clamped to [0, 48].

Rate change and halt:
- A change of `sel` takes effect at the next divider wrap. If the counter is beyond the new N-1, it wraps immediately to 0.
- sel = 3: the divider is held at 0, irq is held 0, and no decode occurs. sound, acc and idx are held.
- Leaving sel = 3 resumes counting from 0.

No cen:
- With cen=0 continuously, all state and outputs are frozen.

Decomposition:
- Package `adpcm5205_pkg` holds:
  - STEP_TABLE, 49 entries of 11 bits: 16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552
  - ADJ, 8 signed entries
  - divider constants 96/64/48
  - sample width 12
- One natural sub-module: `adpcm5205_dec`. It is purely combinational: (acc, idx, nibble) → (acc_next, idx_next).
- The top level contains the divider, irq generation, and state registers.

Test Plan:
- Reset, then release with sel=0 and a cen every 4th clk → irq is low during reset. After release irq rises, then has a period of 384 clk (96 cen) and is high for 48 cen. sound = 0 until the first decode.
- Fresh start, din = 0 → sound = 2 and idx stays 0. Next din = 8 → sound = 0.
- Fresh start, din = 7 → diff = 16+8+4+2 = 30, so sound = 30 and idx = 8. Next din = 7 at step 34 → diff = 34+17+8+4 = 63, so sound = 93 and idx = 16.
- Repeated din = 7 → idx saturates at 48 and sound saturates at +2047. Then repeated din = 4'hF → sound saturates at -2048 and never wraps.
- sel sweep 0 → 1 → 2 → 3 → irq period becomes 96, 64 and 48 cen in turn. With sel = 3, irq stays 0 and sound is held. Returning to sel = 0 resumes a 96-cen period.
- Reset asserted mid-period after several decodes → sound = 0 and irq = 0 on the next clk. The next decode after release starts from step 16.
